// File: rtl/interrupt_pkg.sv
// Shared types and helpers for the interrupt controller and its priority encoders.
package interrupt_pkg;

  localparam int MAX_IRQ = 16;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  // Width of a channel index: at least one bit even for tiny channel counts.
  function automatic int vec_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports the lowest-index set bit of a request vector.
module irq_priority_encoder
  import interrupt_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        i_req,
  output logic                o_valid,
  output logic [vec_w(N)-1:0] o_index
);

  localparam int IW = vec_w(N);

  // NOTE: defaults assigned before the loop so every path drives both outputs (no latch).
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Nesting interrupt controller: latches requests, arbitrates by fixed priority against
// the in-service set, and hands one vector at a time to the control unit.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int                 NUM_IRQ     = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
  parameter logic [NUM_IRQ-1:0] ENABLE_INIT = '1,
  localparam int                VEC_W       = vec_w(NUM_IRQ)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic               EnableWrite,
  input  logic [NUM_IRQ-1:0] EnableData,
  input  logic               Ack,
  input  logic               Return,
  output logic               InterruptIn,
  output logic [VEC_W-1:0]   Vector,
  output logic               InterruptHandler,
  output logic [NUM_IRQ-1:0] InService,
  output logic [NUM_IRQ-1:0] Enable,
  output logic               ReturnErr
);

  if (NUM_IRQ < 2 || NUM_IRQ > MAX_IRQ) begin : g_bad_num_irq
    $error("interrupt_controller: NUM_IRQ out of range");
  end

  state_e             r_state;
  state_e             w_next_state;
  logic [VEC_W-1:0]   r_vector;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_in_service;
  logic               r_return_err;

  logic [NUM_IRQ-1:0] w_eligible;
  logic               w_cand_valid;
  logic [VEC_W-1:0]   w_cand_idx;
  logic               w_cur_valid;
  logic [VEC_W-1:0]   w_cur_idx;
  logic [VEC_W:0]     w_cur;
  logic               w_request;
  logic               w_take;
  logic [NUM_IRQ-1:0] w_ack_mask;
  logic [NUM_IRQ-1:0] w_after_return;
  logic [NUM_IRQ-1:0] w_rise;

  assign w_eligible = r_pending & r_enable & ~r_in_service;

  irq_priority_encoder #(.N(NUM_IRQ)) u_cand (
    .i_req   (w_eligible),
    .o_valid (w_cand_valid),
    .o_index (w_cand_idx)
  );

  irq_priority_encoder #(.N(NUM_IRQ)) u_cur (
    .i_req   (r_in_service),
    .o_valid (w_cur_valid),
    .o_index (w_cur_idx)
  );

  // With nothing in service the running priority sits just below every channel.
  assign w_cur     = w_cur_valid ? {1'b0, w_cur_idx} : (VEC_W + 1)'(NUM_IRQ);
  assign w_request = w_cand_valid && ({1'b0, w_cand_idx} < w_cur);
  assign w_take    = (r_state == REQ) && Ack;

  assign w_ack_mask     = w_take ? (NUM_IRQ'(1) << r_vector) : '0;
  assign w_after_return = (Return && (|r_in_service))
                          ? (r_in_service & (r_in_service - NUM_IRQ'(1)))
                          : r_in_service;
  assign w_rise         = IRQ & ~r_prev;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (w_request) w_next_state = REQ;
      REQ:  if (Ack)       w_next_state = IDLE;
      default:             w_next_state = IDLE;
    endcase
  end

  always_comb begin
    InterruptIn = (r_state == REQ);
  end

  // Return is applied before Ack, so a simultaneous pair swaps one in-service bit for another.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vector     <= '0;
      r_pending    <= '0;
      r_prev       <= '0;
      r_enable     <= ENABLE_INIT;
      r_in_service <= '0;
      r_return_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_request) begin
        r_vector <= w_cand_idx;
      end
      r_pending    <= (EDGE_MASK & ((r_pending & ~w_ack_mask) | w_rise))
                    | (~EDGE_MASK & IRQ);
      r_prev       <= IRQ;
      if (EnableWrite) begin
        r_enable <= EnableData;
      end
      r_in_service <= w_after_return | w_ack_mask;
      r_return_err <= Return && !(|r_in_service);
    end
  end

  assign Vector           = r_vector;
  assign InService        = r_in_service;
  assign InterruptHandler = |r_in_service;
  assign Enable           = r_enable;
  assign ReturnErr        = r_return_err;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with a per-cycle reference model and literal checks.
module tb_interrupt_controller;

  localparam int         N     = 4;
  localparam logic [3:0] EMASK = 4'b0001;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] IRQ = '0;
  logic       EnableWrite = 1'b0;
  logic [3:0] EnableData = '0;
  logic       Ack = 1'b0;
  logic       Return = 1'b0;
  logic       InterruptIn;
  logic [1:0] Vector;
  logic       InterruptHandler;
  logic [3:0] InService;
  logic [3:0] Enable;
  logic       ReturnErr;

  interrupt_controller #(
    .NUM_IRQ     (N),
    .EDGE_MASK   (EMASK),
    .ENABLE_INIT (4'b1111)
  ) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .IRQ              (IRQ),
    .EnableWrite      (EnableWrite),
    .EnableData       (EnableData),
    .Ack              (Ack),
    .Return           (Return),
    .InterruptIn      (InterruptIn),
    .Vector           (Vector),
    .InterruptHandler (InterruptHandler),
    .InService        (InService),
    .Enable           (Enable),
    .ReturnErr        (ReturnErr)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: per-channel rules evaluated with plain loops over channel numbers.
  bit [3:0] m_pend, m_prev, m_en, m_isr;
  bit       m_req, m_err;
  int       m_vec;

  always @(posedge CLK or negedge RST_N) begin : model
    int       cand, cur, vec_n;
    bit       req_n, acked;
    bit [3:0] isr_n, pend_n;
    if (!RST_N) begin
      m_pend = '0; m_prev = '0; m_en = 4'b1111; m_isr = '0;
      m_req = 1'b0; m_err = 1'b0; m_vec = 0;
    end else begin
      cand = N;
      cur  = N;
      for (int i = N - 1; i >= 0; i--) begin
        if (m_pend[i] && m_en[i] && !m_isr[i]) cand = i;
        if (m_isr[i]) cur = i;
      end
      acked = m_req && Ack;
      isr_n = m_isr;
      if (Return && cur < N) isr_n[cur] = 1'b0;
      if (acked) isr_n[m_vec] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (EMASK[i]) pend_n[i] = (IRQ[i] && !m_prev[i]) || (m_pend[i] && !(acked && m_vec == i));
        else          pend_n[i] = IRQ[i];
      end
      req_n = m_req;
      vec_n = m_vec;
      if (!m_req && cand < cur) begin
        req_n = 1'b1;
        vec_n = cand;
      end else if (acked) begin
        req_n = 1'b0;
      end
      m_err  = Return && (m_isr == 0);
      m_isr  = isr_n;
      m_pend = pend_n;
      m_prev = IRQ;
      if (EnableWrite) m_en = EnableData;
      m_req  = req_n;
      m_vec  = vec_n;
    end
  end

  always @(negedge CLK) begin : compare
    check("cmp_InterruptIn", 32'(InterruptIn), 32'(m_req));
    if (m_req) check("cmp_Vector", 32'(Vector), 32'(m_vec));
    check("cmp_InService", 32'(InService), 32'(m_isr));
    check("cmp_InterruptHandler", 32'(InterruptHandler), 32'(|m_isr));
    check("cmp_Enable", 32'(Enable), 32'(m_en));
    check("cmp_ReturnErr", 32'(ReturnErr), 32'(m_err));
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_ack();
    Ack = 1'b1; step(1); Ack = 1'b0;
  endtask

  task automatic pulse_return();
    Return = 1'b1; step(1); Return = 1'b0;
  endtask

  initial begin
    step(2);
    RST_N = 1'b1;
    step(1);
    check("reset_req", 32'(InterruptIn), 0);
    check("reset_enable", 32'(Enable), 32'h f);

    // Level channel 2: request two edges after the line rises, no re-request once in service.
    IRQ[2] = 1'b1;
    step(1);
    check("level_not_yet", 32'(InterruptIn), 0);
    step(1);
    check("level_req", 32'(InterruptIn), 1);
    check("level_vec", 32'(Vector), 2);
    pulse_ack();
    check("level_isr", 32'(InService), 32'h4);
    check("level_req_drop", 32'(InterruptIn), 0);
    step(4);
    check("level_no_rereq", 32'(InterruptIn), 0);

    // Nesting: edge channel 0 preempts channel 2.
    IRQ[0] = 1'b1;
    step(2);
    check("nest_req", 32'(InterruptIn), 1);
    check("nest_vec", 32'(Vector), 0);
    pulse_ack();
    check("nest_isr", 32'(InService), 32'h5);
    IRQ = '0;
    pulse_return();
    check("nest_ret1", 32'(InService), 32'h4);
    pulse_return();
    check("nest_ret2", 32'(InService), 32'h0);
    check("nest_no_err", 32'(ReturnErr), 0);
    step(2);

    // Blocking: channel 3 waits behind channel 1 until its return.
    IRQ[1] = 1'b1;
    step(2);
    check("blk_vec1", 32'(Vector), 1);
    pulse_ack();
    IRQ[1] = 1'b0;
    check("blk_isr", 32'(InService), 32'h2);
    IRQ[3] = 1'b1;
    step(4);
    check("blk_blocked", 32'(InterruptIn), 0);
    pulse_return();
    check("blk_after_ret", 32'(InterruptIn), 0);
    step(1);
    check("blk_req", 32'(InterruptIn), 1);
    check("blk_vec3", 32'(Vector), 3);
    IRQ[3] = 1'b0;
    pulse_ack();
    pulse_return();
    step(2);

    // Masking: pending channel 1 held off while disabled, then Vector stable against channel 0.
    IRQ[1] = 1'b1; EnableWrite = 1'b1; EnableData = 4'b1101;
    step(1);
    EnableWrite = 1'b0;
    step(4);
    check("mask_enable", 32'(Enable), 32'hd);
    check("mask_held", 32'(InterruptIn), 0);
    EnableWrite = 1'b1; EnableData = 4'b1111;
    step(1);
    EnableWrite = 1'b0;
    check("mask_reenable_lat", 32'(InterruptIn), 0);
    step(1);
    check("mask_req", 32'(InterruptIn), 1);
    check("mask_vec1", 32'(Vector), 1);
    IRQ[0] = 1'b1;
    step(3);
    check("stable_vec", 32'(Vector), 1);
    check("stable_req", 32'(InterruptIn), 1);
    IRQ = '0;
    pulse_ack();
    check("stable_isr", 32'(InService), 32'h2);
    step(1);
    check("preempt_vec0", 32'(Vector), 0);
    check("preempt_req", 32'(InterruptIn), 1);

    // Ack and Return together: Return clears bit 1, then Ack sets bit 0.
    Ack = 1'b1; Return = 1'b1;
    step(1);
    Ack = 1'b0; Return = 1'b0;
    check("ackret_isr", 32'(InService), 32'h1);
    pulse_return();
    check("ackret_clear", 32'(InService), 32'h0);

    // Spurious return.
    pulse_return();
    check("reterr_pulse", 32'(ReturnErr), 1);
    step(1);
    check("reterr_one_cycle", 32'(ReturnErr), 0);
    check("reterr_isr", 32'(InService), 32'h0);

    // Asynchronous reset mid-REQ with channel 1 in service.
    IRQ[1] = 1'b1;
    step(2);
    pulse_ack();
    IRQ = 4'b0001;
    step(2);
    check("prerst_req", 32'(InterruptIn), 1);
    check("prerst_isr", 32'(InService), 32'h2);
    #3 RST_N = 1'b0;
    IRQ = '0;
    #1;
    check("rst_req", 32'(InterruptIn), 0);
    check("rst_vec", 32'(Vector), 0);
    check("rst_isr", 32'(InService), 0);
    check("rst_handler", 32'(InterruptHandler), 0);
    check("rst_enable", 32'(Enable), 32'hf);
    check("rst_err", 32'(ReturnErr), 0);
    step(1);
    RST_N = 1'b1;
    step(3);
    check("postrst_req", 32'(InterruptIn), 0);
    check("postrst_isr", 32'(InService), 0);

    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
